sd_spi_master: RTL and testbench
================================

Name: sd_spi_master

Overview:
- SPI master that executes the SD-card byte transfers requested by the Z80 port logic.
- The port logic issues a one-fclk `sd_start` strobe together with the byte to send. This block shifts that byte out on SD MOSI while shifting in from MISO, then presents the received byte for the next `SDDAT` read.
- Runs entirely on fclk. Sits between the Z80 port decoder and the SD card pins.

Parameters:
- CLK_DIV, 2, SPI half-period in fclk cycles (>=1). SCK period = 2*CLK_DIV fclk cycles.

Ports:
- fclk  in  1  global FPGA clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- sd_start  in  1  one-fclk transfer request strobe
- sd_datain  in  8  byte to transmit; sampled only in the cycle sd_start is accepted/pended
- sd_dataout  out  8  last fully received byte
- sd_busy  out  1  transfer in progress or pending
- sd_done  out  1  one-fclk pulse when sd_dataout is updated
- sdclk  out  1  SPI SCK
- sddo  out  1  SPI MOSI
- sddi  in  1  SPI MISO

Behaviour:
- Reset values (rst high at a clock edge) apply the next cycle:
  - sdclk=0, sddo=1, sd_dataout=8'hFF, sd_busy=0, sd_done=0
  - state=IDLE, pending flag=0, divider=0, bit counter=0
- Reset mid-transfer aborts immediately. No sd_done is produced and sd_dataout is unchanged by the partial byte (it resets to FF).
- SPI mode 0, MSB first:
  - sdclk idles low.
  - sddo is valid before the first rising edge and changes only on falling edges.
  - sddi is sampled at the fclk edge that drives sdclk high.
- States: IDLE, XFER.
- IDLE:
  - sdclk=0 and sddo holds its last value (1 after reset).
  - sd_start=1 at edge T: tx_shift<=sd_datain, sddo<=sd_datain[7], divider<=0, toggle count<=0, sd_busy<=1, go to XFER.
- XFER:
  - The divider counts 0..CLK_DIV-1. At terminal count sdclk toggles and the toggle count increments (0..15).
  - Rising toggle (count even -> sdclk 0->1): rx_shift <= {rx_shift[6:0], sddi}.
  - Falling toggle, not the last: tx_shift shifts left and sddo <= next bit.
  - The 16th toggle (final falling edge) occurs at edge T+16*CLK_DIV:
    - sd_dataout <= received byte, including the bit sampled on the 8th rise.
    - sd_done=1 for exactly that one following cycle.
    - If the pending flag is set, or sd_start=1 in that same cycle: load the new byte (pending data, or sd_datain if sd_start is present; sd_start wins), restart at count 0 with no idle gap. sd_busy stays 1 and the pending flag clears.
    - Otherwise go to IDLE with sd_busy<=0.
- sd_start while in XFER (not the final edge): set the pending flag and capture sd_datain into pend_data. A further start overwrites pend_data (one-deep, last wins). Never corrupts the current byte.
- sd_busy = (state==XFER) | pending.
- Throughput: back-to-back bytes take exactly 16*CLK_DIV fclk each.
- sd_dataout changes only on completion. It is stable during the next transfer, so reads of `SDDAT` return the previous byte.
- Counters are unsigned and wrap-free: toggle count is 4 bits, 0..15, and the end is detected at 15 with the divider at terminal count.

Test Plan:
- Reset: hold rst 3 cycles mid-transfer -> next cycle sdclk=0, sddo=1, sd_busy=0, sd_dataout=FF, sd_done=0; no sd_done afterwards.
- Loopback (sddi=sddo), CLK_DIV=2, start with A5 at edge T:
  - Required: sd_busy high T+1..T+32, sd_done at T+33, sd_dataout=A5.
  - Required: 8 sdclk rising edges, MOSI sequence 1,0,1,0,0,1,0,1.
- sddi tied 0, send FF -> sd_dataout=00. Then sddi tied 1, send 00 -> sd_dataout=FF and sddo low throughout the second byte.
- Start 3C, then mid-transfer start C3 and C4 -> second byte transmitted is C4, starting the cycle after the first byte's final fall with no idle gap; sd_busy never drops between bytes; two sd_done pulses 32 cycles apart.
- sd_start coincident with the completion edge (sending 81) -> that byte starts immediately; the first completion's sd_done still pulses.
- CLK_DIV=1: byte 5A in loopback -> sdclk toggles every fclk, completes in 16 cycles, sd_dataout=5A.

Source files
------------

// File: rtl/sd_spi_master.sv
// SPI mode-0 master for SD card byte transfers, MSB first, with a one-deep
// pending request so back-to-back bytes run without an idle gap.
module sd_spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       sd_start,
  input  logic [7:0] sd_datain,
  output logic [7:0] sd_dataout,
  output logic       sd_busy,
  output logic       sd_done,
  output logic       sdclk,
  output logic       sddo,
  input  logic       sddi
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state, state_nx;
  logic          pending, pending_nx;
  logic [7:0]    pend_data, pend_data_nx;
  logic [7:0]    tx_shift, tx_shift_nx;
  logic [7:0]    rx_shift, rx_shift_nx;
  logic [DW-1:0] div, div_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          sdclk_nx, sddo_nx, sd_done_nx;
  logic [7:0]    sd_dataout_nx;
  logic          div_tc, last;
  logic [7:0]    next_byte;

  assign div_tc  = (div == DIV_TC);
  assign last    = div_tc && (cnt == 4'd15);
  assign sd_busy = (state == XFER) | pending;

  always_comb begin
    state_nx      = state;
    pending_nx    = pending;
    pend_data_nx  = pend_data;
    tx_shift_nx   = tx_shift;
    rx_shift_nx   = rx_shift;
    div_nx        = div;
    cnt_nx        = cnt;
    sdclk_nx      = sdclk;
    sddo_nx       = sddo;
    sd_dataout_nx = sd_dataout;
    sd_done_nx    = 1'b0;
    next_byte     = sd_start ? sd_datain : pend_data;

    case (state)
      IDLE: begin
        sdclk_nx = 1'b0;
        if (sd_start) begin
          tx_shift_nx = sd_datain;
          sddo_nx     = sd_datain[7];
          div_nx      = '0;
          cnt_nx      = 4'd0;
          state_nx    = XFER;
        end
      end
      XFER: begin
        // a start landing on the final edge is consumed directly below
        if (sd_start && !last) begin
          pending_nx   = 1'b1;
          pend_data_nx = sd_datain;
        end
        if (!div_tc) begin
          div_nx = div + DW'(1);
        end else begin
          div_nx   = '0;
          sdclk_nx = ~sdclk;
          cnt_nx   = cnt + 4'd1;
          if (!cnt[0]) begin
            rx_shift_nx = {rx_shift[6:0], sddi};
          end else if (!last) begin
            tx_shift_nx = {tx_shift[6:0], 1'b0};
            sddo_nx     = tx_shift[6];
          end else begin
            sd_dataout_nx = rx_shift;
            sd_done_nx    = 1'b1;
            cnt_nx        = 4'd0;
            if (sd_start || pending) begin
              tx_shift_nx = next_byte;
              sddo_nx     = next_byte[7];
              pending_nx  = 1'b0;
            end else begin
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      pend_data  <= 8'h00;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      div        <= '0;
      cnt        <= 4'd0;
      sdclk      <= 1'b0;
      sddo       <= 1'b1;
      sd_dataout <= 8'hFF;
      sd_done    <= 1'b0;
    end else begin
      state      <= state_nx;
      pending    <= pending_nx;
      pend_data  <= pend_data_nx;
      tx_shift   <= tx_shift_nx;
      rx_shift   <= rx_shift_nx;
      div        <= div_nx;
      cnt        <= cnt_nx;
      sdclk      <= sdclk_nx;
      sddo       <= sddo_nx;
      sd_dataout <= sd_dataout_nx;
      sd_done    <= sd_done_nx;
    end
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: directed and random byte transfers checked against
// a transaction-level model (bytes sent, bytes received, fixed per-byte latency).
module tb_sd_spi_master;

  logic       fclk = 1'b0;
  logic       rst;
  logic       sd_start;
  logic [7:0] sd_datain;
  logic [7:0] sd_dataout;
  logic       sd_busy, sd_done, sdclk, sddo, sddi;
  int         mode;

  logic       sd_start1;
  logic [7:0] sd_datain1;
  logic [7:0] sd_dataout1;
  logic       sd_busy1, sd_done1, sdclk1, sddo1;

  int n_assert = 0;
  int n_fail   = 0;

  localparam int N = 32;

  assign sddi = (mode == 0) ? sddo : (mode == 2);

  sd_spi_master #(.CLK_DIV(2)) dut (
    .fclk(fclk), .rst(rst), .sd_start(sd_start), .sd_datain(sd_datain),
    .sd_dataout(sd_dataout), .sd_busy(sd_busy), .sd_done(sd_done),
    .sdclk(sdclk), .sddo(sddo), .sddi(sddi)
  );

  sd_spi_master #(.CLK_DIV(1)) dut1 (
    .fclk(fclk), .rst(rst), .sd_start(sd_start1), .sd_datain(sd_datain1),
    .sd_dataout(sd_dataout1), .sd_busy(sd_busy1), .sd_done(sd_done1),
    .sdclk(sdclk1), .sddo(sddo1), .sddi(sddo1)
  );

  always #5 fclk = ~fclk;

  // MOSI as seen by the card: one bit per SCK rising edge
  logic sdclk_q = 1'b0;
  int   rises = 0;
  logic mosi_q[$];
  always @(negedge fclk) begin
    if (sdclk && !sdclk_q) begin
      rises++;
      mosi_q.push_back(sddo);
    end
    sdclk_q = sdclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One byte lasts N edges from its start edge; optional extra starts at edges ik1/ik2.
  task automatic track(input string tag, input bit do_start, input logic [7:0] tx,
                       input logic [7:0] exp_rx, input bit busy_after,
                       input int ik1, input logic [7:0] ib1,
                       input int ik2, input logic [7:0] ib2);
    logic [7:0] prev_out;
    logic [7:0] got_tx;
    prev_out = sd_dataout;
    mosi_q.delete();
    rises = 0;
    if (do_start) begin
      sd_start = 1'b1;
      sd_datain = tx;
      @(posedge fclk); #1;
      sd_start = 1'b0;
      sd_datain = 8'($urandom);
    end
    for (int k = 1; k <= N; k++) begin
      if (k == ik1) begin sd_start = 1'b1; sd_datain = ib1; end
      if (k == ik2) begin sd_start = 1'b1; sd_datain = ib2; end
      @(posedge fclk); #1;
      sd_start = 1'b0;
      if (k < N) begin
        chk({tag, "_busy"}, sd_busy, 1'b1);
        chk({tag, "_nodone"}, sd_done, 1'b0);
        chk({tag, "_hold_out"}, sd_dataout, prev_out);
        if (tx == 8'h00 || tx == 8'hFF) chk({tag, "_sddo_const"}, sddo, tx[0]);
      end else begin
        chk({tag, "_done"}, sd_done, 1'b1);
        chk({tag, "_rx"}, sd_dataout, exp_rx);
        chk({tag, "_busy_after"}, sd_busy, busy_after);
      end
    end
    chk({tag, "_rises"}, rises, 8);
    got_tx = 8'h00;
    foreach (mosi_q[i]) got_tx = {got_tx[6:0], mosi_q[i]};
    chk({tag, "_mosi"}, got_tx, tx);
  endtask

  initial begin
    logic [7:0] bytes[6];
    int         ik;
    logic       prev;

    rst = 1'b1; sd_start = 1'b0; sd_datain = 8'h00; mode = 0;
    sd_start1 = 1'b0; sd_datain1 = 8'h00;
    repeat (3) @(posedge fclk);
    #1;
    chk("rst_sdclk", sdclk, 1'b0);
    chk("rst_sddo", sddo, 1'b1);
    chk("rst_out", sd_dataout, 8'hFF);
    chk("rst_busy", sd_busy, 1'b0);
    chk("rst_done", sd_done, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge fclk);
    #1;

    mode = 0;
    track("lb_a5", 1, 8'hA5, 8'hA5, 0, -1, 8'h00, -1, 8'h00);
    repeat (3) @(posedge fclk);
    #1;
    chk("idle_sdclk", sdclk, 1'b0);
    chk("idle_done", sd_done, 1'b0);

    mode = 1;
    track("tie0_ff", 1, 8'hFF, 8'h00, 0, -1, 8'h00, -1, 8'h00);
    mode = 2;
    track("tie1_00", 1, 8'h00, 8'hFF, 0, -1, 8'h00, -1, 8'h00);

    mode = 0;
    track("b2b_3c", 1, 8'h3C, 8'h3C, 1, 7, 8'hC3, 20, 8'hC4);
    track("b2b_c4", 0, 8'hC4, 8'hC4, 0, -1, 8'h00, -1, 8'h00);

    track("coin_5e", 1, 8'h5E, 8'h5E, 1, N, 8'h81, -1, 8'h00);
    track("coin_81", 0, 8'h81, 8'h81, 0, -1, 8'h00, -1, 8'h00);

    // random chained stream: each next byte requested at a random point
    foreach (bytes[i]) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      ik = (i < 5) ? int'($urandom_range(1, N - 1)) : -1;
      track("rand", (i == 0), bytes[i], bytes[i], (i < 5), ik,
            (i < 5) ? bytes[(i + 1) % 6] : 8'h00, -1, 8'h00);
    end

    // reset mid-transfer with a request pending
    sd_start = 1'b1; sd_datain = 8'h96;
    @(posedge fclk); #1;
    sd_start = 1'b0;
    repeat (4) @(posedge fclk);
    #1;
    sd_start = 1'b1; sd_datain = 8'h69;
    @(posedge fclk); #1;
    sd_start = 1'b0;
    repeat (4) @(posedge fclk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge fclk); #1;
      chk("mrst_sdclk", sdclk, 1'b0);
      chk("mrst_sddo", sddo, 1'b1);
      chk("mrst_busy", sd_busy, 1'b0);
      chk("mrst_out", sd_dataout, 8'hFF);
      chk("mrst_done", sd_done, 1'b0);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge fclk); #1;
      chk("post_rst_done", sd_done, 1'b0);
      chk("post_rst_busy", sd_busy, 1'b0);
      chk("post_rst_sdclk", sdclk, 1'b0);
    end

    // CLK_DIV=1 instance, loopback
    sd_start1 = 1'b1; sd_datain1 = 8'h5A;
    @(posedge fclk); #1;
    sd_start1 = 1'b0;
    prev = sdclk1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge fclk); #1;
      chk("div1_toggle", sdclk1, !prev);
      prev = sdclk1;
      if (k < 16) begin
        chk("div1_nodone", sd_done1, 1'b0);
        chk("div1_busy", sd_busy1, 1'b1);
      end else begin
        chk("div1_done", sd_done1, 1'b1);
        chk("div1_rx", sd_dataout1, 8'h5A);
        chk("div1_busy_after", sd_busy1, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
